// File: rtl/eeprom_i2c_slave_if.sv
// Purpose: groups the I2C responder's clock line and status outputs into one bundle.
// Latency: none, wires only.
// Backpressure: none; SDA stays a plain inout on the module because it is open drain.
// Ports: SCL (master->slave), BUSY and WR_DONE (slave->master), WP (master->slave, EEPROM_WP_EN builds only).
interface eeprom_i2c_slave_if;
  logic SCL;
  logic BUSY;
  logic WR_DONE;
`ifdef EEPROM_WP_EN
  logic WP;
  modport master (output SCL, output WP, input BUSY, input WR_DONE);
  modport slave  (input SCL, input WP, output BUSY, output WR_DONE);
`else
  modport master (output SCL, input BUSY, input WR_DONE);
  modport slave  (input SCL, output BUSY, output WR_DONE);
`endif
endinterface

// File: rtl/eeprom_i2c_slave.sv
// Purpose: I2C responder modelling a 2K x 8 serial EEPROM (24C16-style {DEV_ID, A10..A8} control word).
// Latency: 3 CLK from a pin edge to its detection; SDA changes 1 CLK after a detected SCL fall.
// Backpressure: none; the bus master sets the pace, and NACKs a data byte when WP is high (EEPROM_WP_EN).
// Ports: CLK, rst (sync, active high), SDA (open drain: drives 0 or z), bus.SCL, bus.BUSY, bus.WR_DONE, bus.WP.
// Optional feature macro: EEPROM_WP_EN adds the write-protect input.
module eeprom_i2c_slave #(
  parameter logic [3:0] DEV_ID = 4'b1010,
  parameter int         MEM_AW = 11
) (
  input  logic              CLK,
  input  logic              rst,
  inout  wire               SDA,
  eeprom_i2c_slave_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;

  localparam logic [MEM_AW-1:0] PTR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

  state_t            state, nxt_state;
  logic [2:0]        scl_sr, sda_sr;   // [0] first flop, [1] synced copy, [2] previous synced value
  logic [6:0]        sreg, nxt_sreg;   // bit 8 of a received byte is taken straight from the synced SDA
  logic [2:0]        cnt, nxt_cnt;
  logic [MEM_AW-1:0] ptr, nxt_ptr;
  logic              sda_oe, nxt_oe;
  logic              rw, nxt_rw;
  logic              ack_en, nxt_ack_en;
  logic              wr_done;
  logic              mem_we;
  logic [7:0]        rd_q;
  logic [7:0]        mem [0:(1<<MEM_AW)-1];

  logic       scl_rise, scl_fall, start_det, stop_det, sda_bit, wp_on;
  logic [7:0] rx_byte;

`ifdef EEPROM_WP_EN
  assign wp_on = bus.WP;
`else
  assign wp_on = 1'b0;
`endif

  assign sda_bit   = sda_sr[1];
  assign scl_rise  =  scl_sr[1] & ~scl_sr[2];
  assign scl_fall  = ~scl_sr[1] &  scl_sr[2];
  assign start_det =  scl_sr[1] & scl_sr[2] &  sda_sr[2] & ~sda_sr[1];
  assign stop_det  =  scl_sr[1] & scl_sr[2] & ~sda_sr[2] &  sda_sr[1];
  assign rx_byte   = {sreg, sda_bit};

  assign SDA         = sda_oe ? 1'b0 : 1'bz;
  assign bus.BUSY    = (state != IDLE);
  assign bus.WR_DONE = wr_done;

  always_ff @(posedge CLK) begin
    if (rst) begin
      scl_sr  <= 3'b111;
      sda_sr  <= 3'b111;
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      rw      <= 1'b0;
      ack_en  <= 1'b0;
      wr_done <= 1'b0;
    end else begin
      scl_sr  <= {scl_sr[1:0], bus.SCL};
      sda_sr  <= {sda_sr[1:0], SDA};
      state   <= nxt_state;
      sreg    <= nxt_sreg;
      cnt     <= nxt_cnt;
      ptr     <= nxt_ptr;
      sda_oe  <= nxt_oe;
      rw      <= nxt_rw;
      ack_en  <= nxt_ack_en;
      wr_done <= mem_we;
    end
  end

  // RAM is not reset; rd_q always holds mem[ptr] so a read byte is ready before its first SCL fall.
  always_ff @(posedge CLK) begin
    if (mem_we && !rst) mem[ptr] <= rx_byte;
    rd_q <= mem[ptr];
  end

  always_comb begin
    nxt_state  = state;
    nxt_sreg   = sreg;
    nxt_cnt    = cnt;
    nxt_ptr    = ptr;
    nxt_oe     = sda_oe;
    nxt_rw     = rw;
    nxt_ack_en = ack_en;
    mem_we     = 1'b0;
    if (stop_det) begin
      nxt_state = IDLE;
      nxt_oe    = 1'b0;
      nxt_cnt   = '0;
    end else if (start_det) begin
      nxt_state = DEV;
      nxt_oe    = 1'b0;
      nxt_cnt   = '0;
    end else begin
      case (state)
        DEV: if (scl_rise) begin
          nxt_sreg = rx_byte[6:0];
          nxt_cnt  = cnt + 3'd1;
          if (cnt == 3'd7) begin
            if (rx_byte[7:4] == DEV_ID) begin
              nxt_state                = DEV_ACK;
              nxt_ptr[MEM_AW-1:8]      = rx_byte[MEM_AW-8:1];
              nxt_rw                   = rx_byte[0];
              nxt_ack_en               = 1'b1;
            end else begin
              nxt_state = WAIT_STOP;
            end
          end
        end
        ADDR: if (scl_rise) begin
          nxt_sreg = rx_byte[6:0];
          nxt_cnt  = cnt + 3'd1;
          if (cnt == 3'd7) begin
            nxt_ptr[7:0] = rx_byte;
            nxt_state    = ADDR_ACK;
            nxt_ack_en   = 1'b1;
          end
        end
        WDATA: if (scl_rise) begin
          nxt_sreg = rx_byte[6:0];
          nxt_cnt  = cnt + 3'd1;
          if (cnt == 3'd7) begin
            nxt_state  = WDATA_ACK;
            nxt_ack_en = ~wp_on;
            if (!wp_on) begin
              mem_we  = 1'b1;
              nxt_ptr = ptr + PTR_ONE;
            end
          end
        end
        // Ack slot: cnt 0 = waiting for the fall that opens the slot, 1 = waiting for the fall that closes it.
        DEV_ACK, ADDR_ACK, WDATA_ACK: if (scl_fall) begin
          if (cnt == 3'd0) begin
            nxt_oe  = ack_en;
            nxt_cnt = 3'd1;
          end else begin
            nxt_oe  = 1'b0;
            nxt_cnt = '0;
            if (state == DEV_ACK && rw) begin
              // The fall that closes the ack slot also presents read bit 7.
              nxt_state = RDATA;
              nxt_sreg  = rd_q[6:0];
              nxt_oe    = ~rd_q[7];
              nxt_ptr   = ptr + PTR_ONE;
            end else if (state == DEV_ACK) begin
              nxt_state = ADDR;
            end else begin
              nxt_state = WDATA;
            end
          end
        end
        RDATA: if (scl_fall) begin
          if (cnt == 3'd7) begin
            nxt_oe    = 1'b0;
            nxt_cnt   = '0;
            nxt_state = RACK;
          end else begin
            nxt_oe   = ~sreg[6];
            nxt_sreg = {sreg[5:0], 1'b0};
            nxt_cnt  = cnt + 3'd1;
          end
        end
        RACK: begin
          if (scl_rise && cnt == 3'd0) begin
            if (sda_bit) nxt_state = WAIT_STOP;
            else         nxt_cnt   = 3'd1;
          end else if (scl_fall && cnt == 3'd1) begin
            nxt_state = RDATA;
            nxt_cnt   = '0;
            nxt_sreg  = rd_q[6:0];
            nxt_oe    = ~rd_q[7];
            nxt_ptr   = ptr + PTR_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
